// File: rtl/odo_round_loop.sv
// Round-recirculation loop: each item makes ROUNDS passes through an external LAT-cycle round datapath on an L=LAT+1 slot ring.
// Latency 1+ROUNDS*L cycles to out_valid; in_ready drops on recirculation slots and when OUT_DEPTH credits are outstanding.

module odo_round_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_vld,
  input  logic [W-1:0] wr_dat,
  output logic         rd_vld,
  input  logic         rd_rdy,
  output logic [W-1:0] rd_dat
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rd_pop;

  assign rd_vld = (cnt_q != '0);
  assign rd_dat = mem_q[rd_ptr_q];

  always_comb begin
    rd_pop   = rd_vld && rd_rdy;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_vld) begin
      wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    end
    if (rd_pop) begin
      rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
    end
    cnt_d = cnt_q + CW'(wr_vld) - CW'(rd_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: the count alone decides what is visible.
  always_ff @(posedge clk) begin
    if (wr_vld) begin
      mem_q[wr_ptr_q] <= wr_dat;
    end
  end
endmodule

module odo_round_loop #(
  parameter int  WIDTH     = 640,
  parameter int  ROUNDS    = 84,
  parameter int  LAT       = 2,
  parameter int  TAGW      = 8,
  parameter int  OUT_DEPTH = 4,
  localparam int RW        = (ROUNDS > 1) ? $clog2(ROUNDS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [TAGW-1:0]  in_tag,
  output logic             rf_valid,
  output logic [RW-1:0]    rf_round,
  output logic [WIDTH-1:0] rf_data,
  input  logic [WIDTH-1:0] rf_ret_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAGW-1:0]  out_tag,
  output logic             busy
);
  localparam int            CW   = $clog2(OUT_DEPTH + 1);
  localparam logic [RW-1:0] LAST = RW'(ROUNDS - 1);

  typedef struct packed {
    logic            vld;
    logic [RW-1:0]   round;
    logic [TAGW-1:0] tag;
  } trk_t;

  trk_t                  trk_q [LAT];
  trk_t                  trk_d [LAT];
  trk_t                  ret;
  logic                  rf_valid_q, rf_valid_d;
  logic [RW-1:0]         rf_round_q, rf_round_d;
  logic [WIDTH-1:0]      rf_data_q, rf_data_d;
  logic [TAGW-1:0]       rf_tag_q, rf_tag_d;
  logic [CW-1:0]         credit_q, credit_d;
  logic                  recirc, done, accept, pop;
  logic [WIDTH+TAGW-1:0] fifo_rd_dat;

  always_comb begin
    // Tail of the tracking line lines up with rf_ret_data this cycle.
    ret      = trk_q[LAT-1];
    recirc   = ret.vld && (ret.round != LAST);
    done     = ret.vld && (ret.round == LAST);
    in_ready = !recirc && (credit_q < CW'(OUT_DEPTH));
    accept   = in_valid && in_ready;
    pop      = out_valid && out_ready;
    credit_d = credit_q + CW'(accept) - CW'(pop);

    rf_valid_d = 1'b0;
    rf_round_d = '0;
    rf_data_d  = '0;
    rf_tag_d   = '0;
    if (recirc) begin
      rf_valid_d = 1'b1;
      rf_round_d = ret.round + RW'(1);
      rf_data_d  = rf_ret_data;
      rf_tag_d   = ret.tag;
    end else if (accept) begin
      rf_valid_d = 1'b1;
      rf_data_d  = in_data;
      rf_tag_d   = in_tag;
    end

    trk_d[0] = '{vld: rf_valid_q, round: rf_round_q, tag: rf_tag_q};
    for (int i = 1; i < LAT; i++) begin
      trk_d[i] = trk_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_valid_q <= 1'b0;
      rf_round_q <= '0;
      rf_data_q  <= '0;
      rf_tag_q   <= '0;
      credit_q   <= '0;
      for (int i = 0; i < LAT; i++) begin
        trk_q[i] <= '0;
      end
    end else begin
      rf_valid_q <= rf_valid_d;
      rf_round_q <= rf_round_d;
      rf_data_q  <= rf_data_d;
      rf_tag_q   <= rf_tag_d;
      credit_q   <= credit_d;
      for (int i = 0; i < LAT; i++) begin
        trk_q[i] <= trk_d[i];
      end
    end
  end

  assign rf_valid = rf_valid_q;
  assign rf_round = rf_round_q;
  assign rf_data  = rf_data_q;
  assign busy     = (credit_q != '0);

  // Credits cover every item from acceptance to pop, so this FIFO cannot overflow.
  odo_round_fifo #(
    .W     (WIDTH + TAGW),
    .DEPTH (OUT_DEPTH)
  ) u_out_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_vld (done),
    .wr_dat ({rf_ret_data, ret.tag}),
    .rd_vld (out_valid),
    .rd_rdy (out_ready),
    .rd_dat (fifo_rd_dat)
  );

  assign {out_data, out_tag} = fifo_rd_dat;
endmodule

// File: tb/tb_odo_round_loop.sv
// Directed bench for odo_round_loop: ROUNDS=4 instance plus a ROUNDS=1 instance, datapath = rf_data+1 after 2 cycles.
module tb_odo_round_loop;
  localparam int W  = 32;
  localparam int TW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic          in_valid, in_ready, rf_valid, out_valid, out_ready, busy;
  logic [W-1:0]  in_data, rf_data, rf_ret_data, out_data;
  logic [TW-1:0] in_tag, out_tag;
  logic [1:0]    rf_round;
  logic [W-1:0]  dp_a, dp_b;

  logic          in_valid_1, in_ready_1, rf_valid_1, out_valid_1, out_ready_1, busy_1;
  logic [W-1:0]  in_data_1, rf_data_1, rf_ret_data_1, out_data_1;
  logic [TW-1:0] in_tag_1, out_tag_1;
  logic [0:0]    rf_round_1;
  logic [W-1:0]  dp1_a, dp1_b;

  odo_round_loop #(.WIDTH(W), .ROUNDS(4), .LAT(2), .TAGW(TW), .OUT_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_tag(in_tag),
    .rf_valid(rf_valid), .rf_round(rf_round), .rf_data(rf_data), .rf_ret_data(rf_ret_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
    .busy(busy)
  );

  odo_round_loop #(.WIDTH(W), .ROUNDS(1), .LAT(2), .TAGW(TW), .OUT_DEPTH(4)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_1), .in_ready(in_ready_1), .in_data(in_data_1), .in_tag(in_tag_1),
    .rf_valid(rf_valid_1), .rf_round(rf_round_1), .rf_data(rf_data_1), .rf_ret_data(rf_ret_data_1),
    .out_valid(out_valid_1), .out_ready(out_ready_1), .out_data(out_data_1), .out_tag(out_tag_1),
    .busy(busy_1)
  );

  // Round datapath model: deliberately not reset, so stale returns exist after a reset pulse.
  always @(posedge clk) begin
    dp_a  <= rf_data;
    dp_b  <= dp_a;
    dp1_a <= rf_data_1;
    dp1_b <= dp1_a;
  end
  assign rf_ret_data   = dp_b + 32'd1;
  assign rf_ret_data_1 = dp1_b + 32'd1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        iv;
    logic [31:0] id;
    logic [7:0]  it;
    logic        ordy;
    logic        e_ir;
    logic        e_rfv;
    logic [1:0]  e_rfr;
    logic [31:0] e_rfd;
    logic        e_ov;
    logic [31:0] e_od;
    logic [7:0]  e_ot;
    logic        e_busy;
  } vec_t;

  vec_t        vec [16];
  logic [31:0] exp_d [4];
  logic [7:0]  exp_t [4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int npop, nacc, nout, lat;

    // iv id tag ordy | in_ready rf_valid rf_round rf_data out_valid out_data out_tag busy
    vec[0]  = '{1'b1, 32'h10, 8'h05, 1'b0, 1'b1, 1'b0, 2'd0, 32'h00, 1'b0, 32'h00, 8'h00, 1'b0};
    vec[1]  = '{1'b0, 32'h00, 8'h00, 1'b0, 1'b1, 1'b1, 2'd0, 32'h10, 1'b0, 32'h00, 8'h00, 1'b1};
    vec[2]  = '{1'b0, 32'h00, 8'h00, 1'b0, 1'b1, 1'b0, 2'd0, 32'h00, 1'b0, 32'h00, 8'h00, 1'b1};
    vec[3]  = '{1'b0, 32'h00, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 32'h00, 1'b0, 32'h00, 8'h00, 1'b1};
    vec[4]  = '{1'b0, 32'h00, 8'h00, 1'b0, 1'b1, 1'b1, 2'd1, 32'h11, 1'b0, 32'h00, 8'h00, 1'b1};
    vec[5]  = '{1'b0, 32'h00, 8'h00, 1'b0, 1'b1, 1'b0, 2'd0, 32'h00, 1'b0, 32'h00, 8'h00, 1'b1};
    vec[6]  = '{1'b0, 32'h00, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 32'h00, 1'b0, 32'h00, 8'h00, 1'b1};
    vec[7]  = '{1'b0, 32'h00, 8'h00, 1'b0, 1'b1, 1'b1, 2'd2, 32'h12, 1'b0, 32'h00, 8'h00, 1'b1};
    vec[8]  = '{1'b0, 32'h00, 8'h00, 1'b0, 1'b1, 1'b0, 2'd0, 32'h00, 1'b0, 32'h00, 8'h00, 1'b1};
    vec[9]  = '{1'b0, 32'h00, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 32'h00, 1'b0, 32'h00, 8'h00, 1'b1};
    vec[10] = '{1'b0, 32'h00, 8'h00, 1'b0, 1'b1, 1'b1, 2'd3, 32'h13, 1'b0, 32'h00, 8'h00, 1'b1};
    vec[11] = '{1'b0, 32'h00, 8'h00, 1'b0, 1'b1, 1'b0, 2'd0, 32'h00, 1'b0, 32'h00, 8'h00, 1'b1};
    vec[12] = '{1'b0, 32'h00, 8'h00, 1'b0, 1'b1, 1'b0, 2'd0, 32'h00, 1'b0, 32'h00, 8'h00, 1'b1};
    vec[13] = '{1'b0, 32'h00, 8'h00, 1'b0, 1'b1, 1'b0, 2'd0, 32'h00, 1'b1, 32'h14, 8'h05, 1'b1};
    vec[14] = '{1'b0, 32'h00, 8'h00, 1'b1, 1'b1, 1'b0, 2'd0, 32'h00, 1'b1, 32'h14, 8'h05, 1'b1};
    vec[15] = '{1'b0, 32'h00, 8'h00, 1'b0, 1'b1, 1'b0, 2'd0, 32'h00, 1'b0, 32'h00, 8'h00, 1'b0};

    rst_n = 1'b0;
    in_valid = 1'b0;   in_data = '0;   in_tag = '0;   out_ready = 1'b0;
    in_valid_1 = 1'b0; in_data_1 = '0; in_tag_1 = '0; out_ready_1 = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.rf_valid", rf_valid, 1'b0);
    chk("rst.rf_round", rf_round, 2'd0);
    chk("rst.rf_data", rf_data, 32'h0);
    chk("rst.out_valid", out_valid, 1'b0);
    chk("rst.busy", busy, 1'b0);
    chk("rst.busy_1", busy_1, 1'b0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rel.in_ready", in_ready, 1'b1);
    @(posedge clk); #1;

    // Single item, cycle-by-cycle table
    for (int i = 0; i < 16; i++) begin
      in_valid  = vec[i].iv;
      in_data   = vec[i].id;
      in_tag    = vec[i].it;
      out_ready = vec[i].ordy;
      @(negedge clk);
      chk($sformatf("t%0d.in_ready", i), in_ready, vec[i].e_ir);
      chk($sformatf("t%0d.rf_valid", i), rf_valid, vec[i].e_rfv);
      chk($sformatf("t%0d.rf_round", i), rf_round, vec[i].e_rfr);
      chk($sformatf("t%0d.rf_data", i), rf_data, vec[i].e_rfd);
      chk($sformatf("t%0d.out_valid", i), out_valid, vec[i].e_ov);
      chk($sformatf("t%0d.busy", i), busy, vec[i].e_busy);
      if (vec[i].e_ov) begin
        chk($sformatf("t%0d.out_data", i), out_data, vec[i].e_od);
        chk($sformatf("t%0d.out_tag", i), out_tag, vec[i].e_ot);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;

    // Three items back-to-back
    exp_d[0] = 32'h24; exp_d[1] = 32'h34; exp_d[2] = 32'h44;
    exp_t[0] = 8'h01;  exp_t[1] = 8'h02;  exp_t[2] = 8'h03;
    npop = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      in_valid = (c < 3);
      in_data  = (c == 0) ? 32'h20 : (c == 1) ? 32'h30 : 32'h40;
      in_tag   = 8'(c + 1);
      @(negedge clk);
      chk($sformatf("b2b.c%0d.in_ready", c), in_ready, (c >= 3 && c <= 11) ? 1'b0 : 1'b1);
      if (out_valid && out_ready) begin
        if (npop < 3) begin
          chk($sformatf("b2b.pop%0d.cycle", npop), c, 13 + npop);
          chk($sformatf("b2b.pop%0d.data", npop), out_data, exp_d[npop]);
          chk($sformatf("b2b.pop%0d.tag", npop), out_tag, exp_t[npop]);
        end
        npop++;
      end
      @(posedge clk); #1;
    end
    chk("b2b.npop", npop, 3);
    in_valid = 1'b0;

    // Output stalled with continuous input, then pop on the completion cycle and drain
    exp_d[0] = 32'h104; exp_d[1] = 32'h105; exp_d[2] = 32'h106; exp_d[3] = 32'h110;
    exp_t[0] = 8'h00;   exp_t[1] = 8'h01;   exp_t[2] = 8'h02;   exp_t[3] = 8'h0C;
    npop = 0;
    nacc = 0;
    for (int c = 0; c < 30; c++) begin
      in_valid  = (c < 24);
      in_data   = 32'(256 + c);
      in_tag    = 8'(c);
      out_ready = (c >= 24);
      @(negedge clk);
      if (in_valid && in_ready) nacc++;
      if (c == 12) chk("stall.c12.in_ready", in_ready, 1'b1);
      if (c >= 13 && c <= 24) begin
        chk($sformatf("stall.c%0d.in_ready", c), in_ready, 1'b0);
        chk($sformatf("stall.c%0d.out_valid", c), out_valid, 1'b1);
        chk($sformatf("stall.c%0d.out_data", c), out_data, 32'h104);
      end
      if (c == 25) chk("stall.c25.busy", busy, 1'b1);
      if (out_valid && out_ready) begin
        if (npop < 4) begin
          chk($sformatf("stall.pop%0d.cycle", npop), c, 24 + npop);
          chk($sformatf("stall.pop%0d.data", npop), out_data, exp_d[npop]);
          chk($sformatf("stall.pop%0d.tag", npop), out_tag, exp_t[npop]);
        end
        npop++;
      end
      if (c == 29) begin
        chk("stall.end.busy", busy, 1'b0);
        chk("stall.end.out_valid", out_valid, 1'b0);
      end
      @(posedge clk); #1;
    end
    chk("stall.accepts", nacc, 4);
    chk("stall.npop", npop, 4);
    in_valid = 1'b0;

    // Reset pulse with two items in flight
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      in_valid = (c < 2);
      in_data  = 32'(96 + c);
      in_tag   = 8'(10 + c);
      @(negedge clk);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst2.rf_valid", rf_valid, 1'b0);
    chk("rst2.rf_round", rf_round, 2'd0);
    chk("rst2.rf_data", rf_data, 32'h0);
    chk("rst2.out_valid", out_valid, 1'b0);
    chk("rst2.busy", busy, 1'b0);
    @(posedge clk); #1 rst_n = 1'b1;
    nout = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (c == 0) chk("rst2.in_ready", in_ready, 1'b1);
      if (out_valid) nout++;
      @(posedge clk); #1;
    end
    chk("rst2.no_output", nout, 0);
    chk("rst2.busy_after", busy, 1'b0);

    in_valid = 1'b1;
    in_data  = 32'h77;
    in_tag   = 8'h3C;
    lat = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == 0) chk("rst2.new.in_ready", in_ready, 1'b1);
      if (out_valid && lat < 0) begin
        lat = c;
        chk("rst2.new.data", out_data, 32'h7B);
        chk("rst2.new.tag", out_tag, 8'h3C);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    chk("rst2.new.latency", lat, 13);

    // ROUNDS=1 instance
    exp_d[0] = 32'h71; exp_d[1] = 32'h72; exp_d[2] = 32'h73;
    exp_t[0] = 8'h07;  exp_t[1] = 8'h08;  exp_t[2] = 8'h09;
    npop = 0;
    out_ready_1 = 1'b1;
    for (int c = 0; c < 10; c++) begin
      in_valid_1 = (c < 3);
      in_data_1  = 32'(112 + c);
      in_tag_1   = 8'(7 + c);
      @(negedge clk);
      chk($sformatf("r1.c%0d.in_ready", c), in_ready_1, 1'b1);
      if (out_valid_1 && out_ready_1) begin
        if (npop < 3) begin
          chk($sformatf("r1.pop%0d.cycle", npop), c, 4 + npop);
          chk($sformatf("r1.pop%0d.data", npop), out_data_1, exp_d[npop]);
          chk($sformatf("r1.pop%0d.tag", npop), out_tag_1, exp_t[npop]);
        end
        npop++;
      end
      @(posedge clk); #1;
    end
    chk("r1.npop", npop, 3);
    in_valid_1 = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
